// File: rtl/quadratic_solver.sv
// Finds the smallest x in 0..255 with a*x^2 + b*x + c == y (mod 2^16), using forward differences.
// Define QUADRATIC_SOLVER_COUNT_EN to sweep the whole range and count roots on num_raizes.
module quadratic_solver (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] y,
    input  logic        inicio,
    output logic        pronto,
    output logic        encontrado,
    output logic [7:0]  x
`ifdef QUADRATIC_SOLVER_COUNT_EN
   ,output logic [8:0]  num_raizes
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] a_q, y_q, f, d;
    logic [7:0]  idx, x_q;
    logic        found_q;
    logic        match, last;
`ifdef QUADRATIC_SOLVER_COUNT_EN
    logic [8:0]  cnt_q;
`endif

    assign match = (f == y_q);
    assign last  = (idx == 8'hFF);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (inicio) state_next = BUSY;
`ifdef QUADRATIC_SOLVER_COUNT_EN
            BUSY: if (last) state_next = DONE;
`else
            BUSY: if (match || last) state_next = DONE;
`endif
            DONE: if (!inicio) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // f tracks f(idx); d tracks f(idx+1)-f(idx), which grows by 2a per step
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            y_q     <= '0;
            f       <= '0;
            d       <= '0;
            idx     <= '0;
            x_q     <= '0;
            found_q <= 1'b0;
`ifdef QUADRATIC_SOLVER_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (inicio) begin
                        a_q   <= a;
                        y_q   <= y;
                        f     <= c;
                        d     <= a + b;
                        idx   <= '0;
`ifdef QUADRATIC_SOLVER_COUNT_EN
                        cnt_q <= '0;
`endif
                    end
                end
                BUSY: begin
                    f   <= f + d;
                    d   <= d + (a_q << 1);
                    idx <= idx + 8'd1;
`ifdef QUADRATIC_SOLVER_COUNT_EN
                    if (match) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (cnt_q == '0) x_q <= idx;
                    end
                    if (last) begin
                        found_q <= (cnt_q != '0) || match;
                        if ((cnt_q == '0) && !match) x_q <= '1;
                    end
`else
                    if (match) begin
                        x_q     <= idx;
                        found_q <= 1'b1;
                    end else if (last) begin
                        x_q     <= '1;
                        found_q <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign pronto     = (state == DONE);
    assign encontrado = found_q;
    assign x          = x_q;
`ifdef QUADRATIC_SOLVER_COUNT_EN
    assign num_raizes = cnt_q;
`endif

endmodule

// File: tb/tb_quadratic_solver.sv
// Scoreboard bench for quadratic_solver: a direct-evaluation model predicts result and latency per request.
module tb_quadratic_solver;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] a = '0, b = '0, c = '0, y = '0;
    logic        inicio = 1'b0;
    logic        pronto, encontrado;
    logic [7:0]  x;
`ifdef QUADRATIC_SOLVER_COUNT_EN
    logic [8:0]  num_raizes;
`endif

    quadratic_solver dut (
        .clock      (clock),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .c          (c),
        .y          (y),
        .inicio     (inicio),
        .pronto     (pronto),
        .encontrado (encontrado),
        .x          (x)
`ifdef QUADRATIC_SOLVER_COUNT_EN
       ,.num_raizes (num_raizes)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  x;
        logic        found;
        logic [8:0]  cnt;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fx(input logic [15:0] fa, fb, fc, input int unsigned i);
        int unsigned v;
        v = fa * i * i + fb * i + fc;
        return v[15:0];
    endfunction

    function automatic exp_t model(input logic [15:0] ma, mb, mc, my);
        exp_t        e;
        int unsigned first;
        first = 256;
        e.cnt = '0;
        for (int unsigned i = 0; i < 256; i++) begin
            if (fx(ma, mb, mc, i) == my) begin
                if (first == 256) first = i;
                e.cnt = e.cnt + 9'd1;
            end
        end
        e.found = (first != 256);
        e.x     = e.found ? first[7:0] : 8'hFF;
`ifdef QUADRATIC_SOLVER_COUNT_EN
        e.lat   = 256;
`else
        e.lat   = e.found ? first + 1 : 256;
`endif
        return e;
    endfunction

    task automatic start_op(input logic [15:0] sa, sb_, sc, sy);
        @(negedge clock);
        a = sa; b = sb_; c = sc; y = sy;
        inicio = 1'b1;
        sb.push_back(model(sa, sb_, sc, sy));
    endtask

    // Waits for pronto, compares against the scoreboard, then holds and releases inicio
    task automatic finish_op(input int unsigned hold, input string tag);
        exp_t        e;
        int unsigned n;
        bit          done;
        n = 0;
        done = 1'b0;
        @(posedge clock); #1;
        check({tag, "_busy_pronto"}, pronto, 0);
        @(negedge clock);
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); y = 16'($urandom);
        while (!done && n < 300) begin
            @(posedge clock); #1;
            n++;
            if (pronto) done = 1'b1;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_x"}, x, e.x);
        check({tag, "_found"}, encontrado, e.found);
`ifdef QUADRATIC_SOLVER_COUNT_EN
        check({tag, "_count"}, num_raizes, e.cnt);
`endif
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({tag, "_hold_pronto"}, pronto, 1);
            check({tag, "_hold_x"}, x, e.x);
        end
        @(negedge clock);
        inicio = 1'b0;
        @(posedge clock); #1;
        check({tag, "_exit_pronto"}, pronto, 0);
        check({tag, "_idle_x"}, x, e.x);
        check({tag, "_idle_found"}, encontrado, e.found);
        @(posedge clock); #1;
        check({tag, "_idle2_pronto"}, pronto, 0);
    endtask

    initial begin
        logic [15:0] ra, rb, rc;
        int unsigned rk;

        #12;
        check("rst_pronto", pronto, 0);
        check("rst_found", encontrado, 0);
        check("rst_x", x, 0);
`ifdef QUADRATIC_SOLVER_COUNT_EN
        check("rst_count", num_raizes, 0);
`endif
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("idle_pronto", pronto, 0);

        start_op(16'd3, 16'd3, 16'd0, 16'd6);      finish_op(0, "root1");
        start_op(16'd3, 16'd3, 16'd0, 16'd7);      finish_op(0, "noroot");
        start_op(16'd1, 16'd0, 16'd0, 16'hFE01);   finish_op(0, "root255");
        start_op(16'd0, 16'd0, 16'd5, 16'd5);      finish_op(10, "const");

        // Abort mid-search with reset, then a fresh request
        @(negedge clock);
        a = 16'd0; b = 16'd1; c = 16'd0; y = 16'd200;
        inicio = 1'b1;
        @(posedge clock);
        repeat (2) @(posedge clock);
        #1 y = 16'd3;
        repeat (48) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_pronto", pronto, 0);
        check("abort_x", x, 0);
        check("abort_found", encontrado, 0);
        inicio = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_idle_pronto", pronto, 0);
        start_op(16'd0, 16'd1, 16'd0, 16'd3);      finish_op(2, "restart");

        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
            rk = $urandom_range(0, 255);
            start_op(ra, rb, rc, fx(ra, rb, rc, rk));
            finish_op(1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/quadratic_solver.md
QUADRATIC_SOLVER -- requirements
Module: quadratic_solver

Interface
REQ-001 clock  input  1  — sole clock; all state updates on rising edge.
REQ-002 reset  input  1  — asynchronous, active-low reset.
REQ-003 a  input  16  — coefficient of x².
REQ-004 b  input  16  — coefficient of x.
REQ-005 c  input  16  — constant term.
REQ-006 y  input  16  — target value to invert.
REQ-007 inicio  input  1  — start request, level-sensitive, held high by the requester until pronto is seen.
REQ-008 pronto  output  1  — search complete; x and encontrado are valid.
REQ-009 encontrado  output  1  — 1 when a root was found.
REQ-010 x  output  8  — smallest x in 0..255 with f(x)==y, or 255 when no root exists.
REQ-011 num_raizes  output  9  — number of roots in 0..255; present only with QUADRATIC_SOLVER_COUNT_EN.

Function
REQ-012 f(x) SHALL be defined as a·x² + b·x + c modulo 2^16, bit-exact with the 16-bit resultado of the quadratic_eq block.
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with inicio=1 at a rising edge, the block SHALL latch a, b, c and y, set f=c, set d=a+b (mod 2^16), set x=0, and go to BUSY.
REQ-015 Input changes after the latch edge SHALL have no effect until the next IDLE→BUSY transition.
REQ-016 Each BUSY cycle SHALL compare f with y, then update f←f+d, d←d+2a and x←x+1, all mod 2^16 (x mod 2^8); no multiplier is used.
REQ-017 Without the count macro, in BUSY on f==y the block SHALL go to DONE with x held at the matching value and encontrado=1.
REQ-018 In BUSY, when x==255 and f!=y, the block SHALL go to DONE with x=255 and encontrado=0; x SHALL NOT wrap to 0.
REQ-019 Latency: with acceptance at edge 0, pronto SHALL rise after edge k+1 for first root k, and after edge 256 when no root exists.
REQ-020 pronto SHALL be 1 only in DONE; encontrado and x SHALL be stable throughout DONE.
REQ-021 In DONE, when inicio=0 at a rising edge the block SHALL return to IDLE; while inicio stays 1 it SHALL remain in DONE.
REQ-022 In IDLE, pronto SHALL be 0, and encontrado and x SHALL hold their last values.
REQ-023 In BUSY and DONE, inicio SHALL be ignored except for the DONE exit in REQ-021.

Reset
REQ-024 When reset=0, asynchronously: state=IDLE, pronto=0, encontrado=0, x=0, num_raizes=0, and all internal f, d and latched operand registers SHALL be 0.
REQ-025 A reset asserted in BUSY or DONE SHALL abort the operation; after release the block SHALL wait in IDLE for inicio.

Configuration
REQ-026 When QUADRATIC_SOLVER_COUNT_EN is defined, port num_raizes SHALL exist and BUSY SHALL always sweep x=0..255, ending in DONE after edge 256.
REQ-027 With QUADRATIC_SOLVER_COUNT_EN, num_raizes SHALL be cleared on acceptance and incremented on each match, with a range of 0..256.
REQ-028 With QUADRATIC_SOLVER_COUNT_EN, x SHALL report the first match, or 255 when there is none, and encontrado SHALL equal (num_raizes!=0).
REQ-029 When QUADRATIC_SOLVER_COUNT_EN is undefined, num_raizes and its logic SHALL be absent and the early-exit behaviour of REQ-017 SHALL apply.

Verification
REQ-030 a=3, b=3, c=0, y=6, inicio held → pronto=1 after edge 2, x=1, encontrado=1; with count enabled, num_raizes=1 and pronto after edge 256.
REQ-031 a=3, b=3, c=0, y=7 → pronto after edge 256, x=255, encontrado=0, num_raizes=0.
REQ-032 a=1, b=0, c=0, y=16'hFE01 → x=255, encontrado=1, pronto after edge 256 (last-value boundary).
REQ-033 a=0, b=0, c=5, y=5 → x=0, pronto after edge 1; with count enabled, num_raizes=256 and pronto after edge 256.
REQ-034 Start a=0, b=1, c=0, y=200, change y to 3 at edge 2, pulse reset low at edge 50 → pronto=0 and IDLE immediately; after a new inicio the result is x=3.
REQ-035 Keep inicio high 10 cycles in DONE, then drop it → pronto stays 1 until the first edge with inicio=0, then goes 0 with x unchanged.
